// File: rtl/dac_tracking_fifo.sv
// Byte-packing sample FIFO between the EP2 byte port and the DAC serializer.
// Optional DAC_FIFO_LEVEL_IRQ_EN adds a registered low-fill indicator.
module dac_tracking_fifo #(
  parameter  int ADDR_WIDTH       = 10,
  parameter  int BYTES_PER_SAMPLE = 3,
  localparam int SW               = 8 * BYTES_PER_SAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_write,
  input  logic                  in_flush,
  output logic [SW-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
`ifdef DAC_FIFO_LEVEL_IRQ_EN
  input  logic [ADDR_WIDTH:0]   low_threshold,
  output logic                  level_low,
`endif
  input  logic                  clear_flags
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_SAMPLE - 1);

  logic [1:0]            byte_cnt;
  logic [SW-1:0]         partial;
  logic [SW-1:0]         assembled;
  logic                  push;
  logic                  pop;
  logic                  push_ok;
  logic                  load;
  logic                  ovf_event;
  logic                  unf_event;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_count;
  logic [ADDR_WIDTH:0]   fill_next;
  logic [SW-1:0]         mem [DEPTH];

  always_comb begin
    assembled = (partial << 8) | SW'(in_data);
    push      = in_write && !in_flush && (byte_cnt == LAST_BYTE);
    pop       = out_valid && out_ready;
    push_ok   = push && (!full || pop);
    ovf_event = push && full && !pop;
    unf_event = out_ready && !out_valid;
    // The head sample lives in out_data, so the RAM holds the rest.
    ram_count = fill_count - {{ADDR_WIDTH{1'b0}}, out_valid};
    load      = (ram_count != '0) && (!out_valid || pop);
    fill_next = fill_count + {{ADDR_WIDTH{1'b0}}, push_ok}
                           - {{ADDR_WIDTH{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (in_flush) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (in_write) begin
      if (byte_cnt == LAST_BYTE) begin
        byte_cnt <= '0;
        partial  <= '0;
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
        partial  <= assembled;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= assembled;
  end

  // Reads never collide with the same-edge write: a load needs ram_count>0,
  // and a write into a RAM holding DEPTH entries is impossible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        out_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      fill_count <= fill_next;
      full       <= (fill_next == DEPTH_CNT);
      empty      <= (fill_next == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_event)        overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (unf_event)        underflow <= 1'b1;
      else if (clear_flags) underflow <= 1'b0;
    end
  end

`ifdef DAC_FIFO_LEVEL_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_low <= 1'b1;
    else       level_low <= (fill_next < low_threshold);
  end
`endif

endmodule

// File: tb/tb_dac_tracking_fifo.sv
// Directed bench for dac_tracking_fifo (BPS=3, DEPTH=1024).
module tb_dac_tracking_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_write = 1'b0;
  logic        in_flush = 1'b0;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] fill_count;
  logic        full, empty, overflow, underflow;
  logic        clear_flags = 1'b0;
`ifdef DAC_FIFO_LEVEL_IRQ_EN
  logic [10:0] low_threshold = 11'd4;
  logic        level_low;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [23:0] exp_q[$];

  dac_tracking_fifo #(.ADDR_WIDTH(10), .BYTES_PER_SAMPLE(3)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_write(in_write),
    .in_flush(in_flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fill_count(fill_count), .full(full),
    .empty(empty), .overflow(overflow), .underflow(underflow),
`ifdef DAC_FIFO_LEVEL_IRQ_EN
    .low_threshold(low_threshold), .level_low(level_low),
`endif
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    in_data = b; in_write = 1'b1;
    @(posedge clk); #1;
    in_write = 1'b0;
  endtask

  task automatic push_sample(input logic [23:0] s);
    write_byte(s[23:16]);
    write_byte(s[15:8]);
    write_byte(s[7:0]);
  endtask

  task automatic pop_once();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Consumes samples while out_valid, comparing against exp_q.
  task automatic drain(output int got, output int errs);
    got = 0; errs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) errs++;
        else begin
          if (out_data !== exp_q[0]) errs++;
          void'(exp_q.pop_front());
        end
        got++;
        out_ready = 1'b1;
      end else begin
        out_ready = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if ({out_valid, full, empty, overflow, underflow} !== 5'b00100)
      $display("FAIL reset_flags: got %b expected 00100",
               {out_valid, full, empty, overflow, underflow});
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 24'h0 || fill_count !== 11'd0)
      $display("FAIL reset_data: got data %h fill %0d expected 0 0", out_data, fill_count);
    else pass_cnt++;
  endtask

  task automatic test_packing();
    write_byte(8'h12);
    write_byte(8'h34);
    write_byte(8'h56);
    total_cnt++;
    if (out_valid !== 1'b0 || fill_count !== 11'd1 || empty !== 1'b0)
      $display("FAIL pack_edgeN: got valid %b fill %0d empty %b expected 0 1 0",
               out_valid, fill_count, empty);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 24'h123456)
      $display("FAIL pack_data: got valid %b data %h expected 1 123456", out_valid, out_data);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    pop_once();
    total_cnt++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || fill_count !== 11'd0)
      $display("FAIL pop_to_empty: got valid %b empty %b fill %0d expected 0 1 0",
               out_valid, empty, fill_count);
    else pass_cnt++;
    write_byte(8'h11);
    write_byte(8'h22);
    in_flush = 1'b1; in_write = 1'b1; in_data = 8'h99;
    @(posedge clk); #1;
    in_flush = 1'b0; in_write = 1'b0;
    write_byte(8'hAA);
    write_byte(8'hBB);
    write_byte(8'hCC);
    total_cnt++;
    if (fill_count !== 11'd1)
      $display("FAIL flush_fill: got %0d expected 1", fill_count);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_data !== 24'hAABBCC || out_valid !== 1'b1)
      $display("FAIL flush_data: got %h valid %b expected aabbcc 1", out_data, out_valid);
    else pass_cnt++;
    pop_once();
  endtask

  task automatic test_overflow();
    int got, errs;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      push_sample(24'h100000 + 24'(i));
      exp_q.push_back(24'h100000 + 24'(i));
    end
    total_cnt++;
    if (full !== 1'b1 || fill_count !== 11'd1024 || overflow !== 1'b0)
      $display("FAIL fill_1024: got full %b fill %0d ovf %b expected 1 1024 0",
               full, fill_count, overflow);
    else pass_cnt++;
    push_sample(24'hDEAD00);
    total_cnt++;
    if (full !== 1'b1 || fill_count !== 11'd1024 || overflow !== 1'b1)
      $display("FAIL push_1025: got full %b fill %0d ovf %b expected 1 1024 1",
               full, fill_count, overflow);
    else pass_cnt++;
    drain(got, errs);
    total_cnt++;
    if (got !== 1024 || errs !== 0)
      $display("FAIL drain_order: got %0d samples %0d errors expected 1024 0", got, errs);
    else pass_cnt++;
    total_cnt++;
    if (empty !== 1'b1 || underflow !== 1'b0 || overflow !== 1'b1)
      $display("FAIL drain_end: got empty %b unf %b ovf %b expected 1 0 1",
               empty, underflow, overflow);
    else pass_cnt++;
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0)
      $display("FAIL clear_overflow: got %b expected 0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    int got, errs;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      push_sample(24'h200000 + 24'(i));
      exp_q.push_back(24'h200000 + 24'(i));
    end
    write_byte(8'h30);
    write_byte(8'h00);
    in_data = 8'h00; in_write = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_write = 1'b0; out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(24'h300000);
    total_cnt++;
    if (fill_count !== 11'd1024 || full !== 1'b1 || overflow !== 1'b0)
      $display("FAIL full_pushpop: got fill %0d full %b ovf %b expected 1024 1 0",
               fill_count, full, overflow);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 24'h200001)
      $display("FAIL pushpop_head: got valid %b data %h expected 1 200001", out_valid, out_data);
    else pass_cnt++;
    drain(got, errs);
    total_cnt++;
    if (got !== 1024 || errs !== 0 || empty !== 1'b1)
      $display("FAIL pushpop_order: got %0d samples %0d errors empty %b expected 1024 0 1",
               got, errs, empty);
    else pass_cnt++;
  endtask

  task automatic test_underflow_reset();
    pop_once();
    total_cnt++;
    if (underflow !== 1'b1 || out_valid !== 1'b0 || fill_count !== 11'd0)
      $display("FAIL underflow_set: got unf %b valid %b fill %0d expected 1 0 0",
               underflow, out_valid, fill_count);
    else pass_cnt++;
    clear_flags = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (underflow !== 1'b1)
      $display("FAIL clear_vs_event: got %b expected 1", underflow);
    else pass_cnt++;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    total_cnt++;
    if (underflow !== 1'b0)
      $display("FAIL clear_underflow: got %b expected 0", underflow);
    else pass_cnt++;
    pop_once();
    write_byte(8'h55);
    write_byte(8'h66);
    push_sample(24'h414243);
    write_byte(8'h44);
    apply_reset();
    total_cnt++;
    if ({out_valid, full, empty, overflow, underflow} !== 5'b00100 ||
        out_data !== 24'h0 || fill_count !== 11'd0)
      $display("FAIL midsample_reset: got flags %b data %h fill %0d expected 00100 0 0",
               {out_valid, full, empty, overflow, underflow}, out_data, fill_count);
    else pass_cnt++;
    push_sample(24'h778899);
    @(posedge clk); #1;
    total_cnt++;
    if (out_data !== 24'h778899 || fill_count !== 11'd1 || out_valid !== 1'b1)
      $display("FAIL post_reset_sample: got %h fill %0d valid %b expected 778899 1 1",
               out_data, fill_count, out_valid);
    else pass_cnt++;
  endtask

`ifdef DAC_FIFO_LEVEL_IRQ_EN
  task automatic test_level_low();
    apply_reset();
    total_cnt++;
    if (level_low !== 1'b1)
      $display("FAIL level_reset: got %b expected 1", level_low);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) push_sample(24'h000100 + 24'(i));
    total_cnt++;
    if (level_low !== 1'b1 || fill_count !== 11'd3)
      $display("FAIL level_fill3: got %b fill %0d expected 1 3", level_low, fill_count);
    else pass_cnt++;
    push_sample(24'h000200);
    total_cnt++;
    if (level_low !== 1'b0 || fill_count !== 11'd4)
      $display("FAIL level_fill4: got %b fill %0d expected 0 4", level_low, fill_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_packing();
    test_flush();
    test_overflow();
    test_full_push_pop();
    test_underflow_reset();
`ifdef DAC_FIFO_LEVEL_IRQ_EN
    test_level_low();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
